convertidor_32a8: RTL and testbench
===================================

// Module: convertidor_32a8
// PURPOSE
//  Transmit-side width converter: takes 32-bit words and emits them one byte per CLK, MSB lane first.
//  PCLK selects how many low-order lanes of each word are active.
//  Mirror of the 8->32 packer on the receive path: a word serialised here under a given PCLK
//  and re-packed there under the same PCLK is reproduced bit-exact.
//  Sits between the PHY's parallel TX data path and the byte-wide lane logic.
// PARAMETERS
//  WORD_W   32  input word width; must equal 4*BYTE_W
//  BYTE_W    8  output byte width
// PORTS
//  CLK       in   1       single clock; all state updates on posedge CLK
//  RESET_L   in   1       reset, asynchronous assert, active-low
//  ENB       in   1       block enable; low = freeze and blank output
//  PCLK      in   2       lane mode: 00/11 = 4 bytes, 01 = 2 bytes, 10 = 1 byte
//  in        in   WORD_W  parallel word to serialise
//  valid_in  in   1       in/PCLK valid this cycle
//  ready_in  out  1       block accepts a word this cycle (valid_in & ready_in = transfer)
//  out       out  BYTE_W  serial byte
//  valid_out out  1       out carries a valid byte
//  bits      out  2       bytes still to send after the current one (debug/status, 0..3)
// BEHAVIOUR
//  Reset (RESET_L=0, async): out=0, valid_out=0, bits=0, FSM=IDLE, ready_in=0 while asserted.
//  FSM: IDLE (nothing held) / SEND (holding a partly sent word).
//  Lane count N is decided by the mode latched at accept: 4, 2 or 1 for PCLK = 00/11, 01 or 10.
//  - Lane selection:
//   - 4 bytes -> in[31:24], in[23:16], in[15:8], in[7:0]
//   - 2 bytes -> in[15:8], in[7:0]
//   - 1 byte  -> in[7:0]
//  - Upper lanes are ignored in 2- and 1-byte modes.
//  ready_in = ENB & RESET_L & (FSM==IDLE | bits==0) -- combinational. This permits back-to-back
//   words with no bubble.
//  Accept edge (valid_in & ready_in):
//   - in and PCLK are registered.
//   - out <= first active byte, valid_out <= 1, bits <= N-1.
//   - FSM <= SEND if N>1, else stays IDLE.
//  Latency: first byte is visible in the cycle after the accept edge. Subsequent bytes follow on
//   consecutive edges while ENB=1.
//  SEND, ENB=1, no new accept: out <= next lane, bits <= bits-1, valid_out <= 1.
//   When bits reaches 0, FSM <= IDLE.
//  Last byte with a new word offered: the accept takes priority. The new word's first byte follows
//   the old word's last byte on the next edge, with no gap.
//  IDLE, no accept: out <= 0, valid_out <= 0.
//  ENB=0 (synchronous):
//   - out <= 0, valid_out <= 0, ready_in = 0.
//   - Held word, bits and FSM are frozen.
//   - When ENB returns, sending resumes with the byte that would have gone next; no byte is lost
//     or repeated.
//  PCLK changes mid-word: no effect on the word in flight; the new mode applies from the next accept.
//  valid_in while ready_in=0: ignored. The source must hold the word until accepted.
//  Reset asserted mid-word: the word is discarded and outputs return to reset values immediately.
// STRUCTURE
//  Shared package / header:
//   - Mode constants MODO_32=2'b00, MODO_16=2'b01, MODO_8=2'b10, MODO_32B=2'b11.
//   - Lane-count function pclk_a_bytes(PCLK) -> 2-bit N-1.
//   - Both this block and the 8->32 packer use these.
//  One natural sub-module, selector_carril: combinational mux
//   (held word, mode, byte index) -> BYTE_W byte.
//  Everything else is one FSM and datapath in this module.
// TESTING
//  1 Reset: RESET_L=0 mid-SEND -> out=0, valid_out=0, bits=0, ready_in=0 with no clock edge.
//  2 32-bit mode: PCLK=00, in=32'hA1B2C3D4 accepted ->
//     out=A1,B2,C3,D4 on 4 consecutive cycles, valid_out=1, bits=3,2,1,0.
//  3 Modes 01 and 10, 1-byte back-to-back:
//     - PCLK=01, in=32'hFFFF1234 -> out=12,34.
//     - PCLK=10, in=32'h000000AB then 32'h000000CD back-to-back -> out=AB,CD with no bubble.
//  4 Streaming in 32-bit mode:
//     - valid_in held high with 32'h01020304, 32'h05060708 -> out=01..08 in 8 consecutive cycles.
//     - ready_in high only on cycles where bits==0 or FSM is IDLE.
//  5 ENB stall: drop ENB for 3 cycles after byte B2 of 32'hA1B2C3D4 ->
//     out=0 and valid_out=0 while low; C3 then D4 follow on re-enable.
//  6 Mode change mid-word: PCLK 00->10 after the first byte of 32'h11223344 -> 22,33,44 still sent.
//     The next word uses 1-byte mode.
//  Scoreboard: loop this block into the 8->32 packer under random PCLK/ENB -> words must match.

Source files
------------

// File: rtl/convertidor_pkg.sv
// Shared definitions for the 32->8 transmit serialiser and its 8->32 receive
// counterpart. Both ends must agree on how the two-bit PCLK lane mode maps
// onto a lane count, so that mapping lives here as a single function.
//   MODO_*        lane-mode encodings carried on PCLK
//   estado_t      serialiser FSM states
//   pclk_a_bytes  lane mode -> (active lane count - 1)
package convertidor_pkg;

    localparam logic [1:0] MODO_32  = 2'b00;
    localparam logic [1:0] MODO_16  = 2'b01;
    localparam logic [1:0] MODO_8   = 2'b10;
    localparam logic [1:0] MODO_32B = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } estado_t;

    // Returns N-1 where N is the number of low-order byte lanes in use.
    // The N-1 form fits in two bits and is directly the "bytes remaining
    // after the first one" count.
    function automatic logic [1:0] pclk_a_bytes(input logic [1:0] pclk);
        logic [1:0] n_menos_1;
        case (pclk)
            MODO_16: n_menos_1 = 2'd1;
            MODO_8:  n_menos_1 = 2'd0;
            default: n_menos_1 = 2'd3;
        endcase
        return n_menos_1;
    endfunction

endpackage

// File: rtl/convertidor_32a8_selector_carril.sv
// Combinational byte-lane mux for the 32->8 serialiser.
//   palabra   in  WORD_W  word being serialised
//   modo      in  2       lane mode of that word
//   indice    in  2       position in the output sequence (0 = first byte sent)
//   byte_sel  out BYTE_W  lane selected for that position
// Bytes go out highest active lane first, so position k of an N-lane word is
// lane (N-1-k), with lane 0 being the least significant byte.
module selector_carril
    import convertidor_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic [WORD_W-1:0] palabra,
    input  logic [1:0]        modo,
    input  logic [1:0]        indice,
    output logic [BYTE_W-1:0] byte_sel
);

    logic [1:0] carril;

    always_comb begin
        carril = pclk_a_bytes(modo) - indice;
        case (carril)
            2'd3:    byte_sel = palabra[4*BYTE_W-1:3*BYTE_W];
            2'd2:    byte_sel = palabra[3*BYTE_W-1:2*BYTE_W];
            2'd1:    byte_sel = palabra[2*BYTE_W-1:BYTE_W];
            default: byte_sel = palabra[BYTE_W-1:0];
        endcase
    end

endmodule

// File: rtl/convertidor_32a8.sv
// Transmit-side width converter: accepts 32-bit words and emits one byte per
// clock, most significant active lane first. PCLK picks 4, 2 or 1 active lanes.
//   CLK        in   clock, all state on the rising edge
//   RESET_L    in   asynchronous active-low reset
//   ENB        in   enable; low freezes the held word and blanks the output
//   PCLK       in   lane mode (00/11 = 4 bytes, 01 = 2, 10 = 1)
//   in         in   word to serialise
//   valid_in   in   in/PCLK valid this cycle
//   ready_in   out  word accepted this cycle when valid_in is also high
//   out        out  serial byte
//   valid_out  out  out carries a valid byte
//   bits       out  bytes still to send after the current one
module convertidor_32a8
    import convertidor_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_L,
    input  logic              ENB,
    input  logic [1:0]        PCLK,
    input  logic [WORD_W-1:0] in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [BYTE_W-1:0] out,
    output logic              valid_out,
    output logic [1:0]        bits
);

    estado_t           estado_q, estado_d;
    logic [WORD_W-1:0] palabra_q, palabra_d;
    logic [1:0]        modo_q, modo_d;
    logic [1:0]        bits_q, bits_d;
    logic [BYTE_W-1:0] out_q, out_d;
    logic              valid_out_q, valid_out_d;

    logic              acepta;
    logic [WORD_W-1:0] sel_palabra;
    logic [1:0]        sel_modo;
    logic [1:0]        sel_indice;
    logic [BYTE_W-1:0] sel_byte;

    // A new word may enter while idle or while the last byte of the previous
    // word is on the output, which gives gap-free back-to-back streaming.
    assign ready_in = ENB & RESET_L & ((estado_q == IDLE) | (bits_q == 2'd0));
    assign acepta   = valid_in & ready_in;

    // One lane mux serves both cases: on accept it picks the first byte of
    // the incoming word; otherwise the next byte of the held word, whose
    // position is (N-1) - (bits-1).
    always_comb begin
        sel_palabra = acepta ? in : palabra_q;
        sel_modo    = acepta ? PCLK : modo_q;
        sel_indice  = acepta ? 2'd0 : (pclk_a_bytes(modo_q) - bits_q + 2'd1);
    end

    selector_carril #(
        .WORD_W (WORD_W),
        .BYTE_W (BYTE_W)
    ) u_selector (
        .palabra  (sel_palabra),
        .modo     (sel_modo),
        .indice   (sel_indice),
        .byte_sel (sel_byte)
    );

    // Next-state and datapath. Holding state and a blank output are the
    // defaults, which is exactly the ENB=0 behaviour, so a disabled cycle
    // falls through with nothing else to do.
    always_comb begin
        estado_d    = estado_q;
        palabra_d   = palabra_q;
        modo_d      = modo_q;
        bits_d      = bits_q;
        out_d       = '0;
        valid_out_d = 1'b0;

        if (ENB) begin
            if (acepta) begin
                palabra_d   = in;
                modo_d      = PCLK;
                out_d       = sel_byte;
                valid_out_d = 1'b1;
                bits_d      = pclk_a_bytes(PCLK);
                estado_d    = (bits_d != 2'd0) ? SEND : IDLE;
            end else if (estado_q == SEND) begin
                out_d       = sel_byte;
                valid_out_d = 1'b1;
                bits_d      = bits_q - 2'd1;
                if (bits_d == 2'd0) begin
                    estado_d = IDLE;
                end
            end
        end
    end

    // State register; reset discards any word in flight.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            estado_q    <= IDLE;
            palabra_q   <= '0;
            modo_q      <= MODO_32;
            bits_q      <= 2'd0;
            out_q       <= '0;
            valid_out_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            palabra_q   <= palabra_d;
            modo_q      <= modo_d;
            bits_q      <= bits_d;
            out_q       <= out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign out       = out_q;
    assign valid_out = valid_out_q;
    assign bits      = bits_q;

endmodule

// File: tb/tb_convertidor_32a8.sv
// Bench for the 32->8 serialiser. Directed scenario tasks check exact cycle
// behaviour; a byte scoreboard fed at every accept checks the output stream.
module tb_convertidor_32a8;

    logic        CLK;
    logic        RESET_L;
    logic        ENB;
    logic [1:0]  PCLK;
    logic [31:0] in_w;
    logic        valid_in;
    logic        ready_in;
    logic [7:0]  out_b;
    logic        valid_out;
    logic [1:0]  bits_o;

    int          checks;
    int          errors;
    logic [7:0]  sb[$];

    convertidor_32a8 dut (
        .CLK       (CLK),
        .RESET_L   (RESET_L),
        .ENB       (ENB),
        .PCLK      (PCLK),
        .in        (in_w),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .out       (out_b),
        .valid_out (valid_out),
        .bits      (bits_o)
    );

    // 10-unit clock period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference byte order for one word: highest active lane first.
    function automatic int lanes_of(input logic [1:0] p);
        case (p)
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 4;
        endcase
    endfunction

    // Scoreboard: at each falling edge compare a valid output byte against
    // the oldest expected byte, then, if a transfer will happen on the next
    // rising edge, enqueue that word's bytes. Reset drops everything queued.
    always @(negedge CLK) begin
        logic [7:0] exp_b;
        if (!RESET_L) begin
            sb.delete();
        end else begin
            if (valid_out) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got %h, required no valid byte", out_b);
                end else begin
                    exp_b = sb.pop_front();
                    if (out_b !== exp_b) begin
                        errors++;
                        $display("[TB] FAIL sb_byte: got %h, required %h", out_b, exp_b);
                    end
                end
            end
            if (valid_in && ready_in) begin
                for (int k = lanes_of(PCLK) - 1; k >= 0; k--) begin
                    sb.push_back(in_w[8*k +: 8]);
                end
            end
        end
    end

    // Present a word and wait (bounded) until it is accepted. Returns at
    // 1 unit after the accept edge with valid_in still high.
    task automatic offer(input logic [31:0] w, input logic [1:0] p, output int waits);
        in_w     = w;
        PCLK     = p;
        valid_in = 1'b1;
        waits    = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (ready_in) begin
                @(posedge CLK);
                #1;
                return;
            end
            waits++;
        end
        checks++;
        errors++;
        $display("[TB] FAIL offer_timeout: word %h not accepted in 50 cycles", w);
    endtask

    task automatic test_reset();
        int w;
        RESET_L  = 1'b0;
        ENB      = 1'b1;
        PCLK     = 2'b00;
        in_w     = 32'h0;
        valid_in = 1'b1;
        #3;
        checks++;
        if (ready_in !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b, required 0", ready_in);
        end
        checks++;
        if (valid_out !== 1'b0 || out_b !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_out: got %b/%h, required 0/00", valid_out, out_b);
        end
        valid_in = 1'b0;
        @(posedge CLK);
        #1;
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;
        // Now assert reset in the middle of a word, away from any edge.
        offer(32'hA1B2C3D4, 2'b00, w);
        valid_in = 1'b0;
        @(posedge CLK);
        #2;
        RESET_L = 1'b0;
        #1;
        checks++;
        if (out_b !== 8'h00 || valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_out: got %h/%b, required 00/0", out_b, valid_out);
        end
        checks++;
        if (bits_o !== 2'd0 || ready_in !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_bits: got bits %0d ready %b, required 0/0", bits_o, ready_in);
        end
        @(posedge CLK);
        #1;
        RESET_L = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_modo32();
        int w;
        logic [7:0] exp_b[4];
        exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        offer(32'hA1B2C3D4, 2'b00, w);
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge CLK);
                #1;
            end
            checks++;
            if (out_b !== exp_b[i] || valid_out !== 1'b1 || bits_o !== 2'(3 - i)) begin
                errors++;
                $display("[TB] FAIL modo32_byte%0d: got %h v%b bits %0d, required %h v1 bits %0d",
                         i, out_b, valid_out, bits_o, exp_b[i], 3 - i);
            end
        end
        @(posedge CLK);
        #1;
        checks++;
        if (valid_out !== 1'b0 || out_b !== 8'h00) begin
            errors++;
            $display("[TB] FAIL modo32_idle: got %b/%h, required 0/00", valid_out, out_b);
        end
    endtask

    task automatic test_modos_16_8();
        int w;
        offer(32'hFFFF1234, 2'b01, w);
        valid_in = 1'b0;
        checks++;
        if (out_b !== 8'h12 || bits_o !== 2'd1) begin
            errors++;
            $display("[TB] FAIL modo16_first: got %h bits %0d, required 12 bits 1", out_b, bits_o);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (out_b !== 8'h34 || bits_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL modo16_second: got %h bits %0d, required 34 bits 0", out_b, bits_o);
        end
        @(posedge CLK);
        #1;
        offer(32'h000000AB, 2'b10, w);
        checks++;
        if (out_b !== 8'hAB || bits_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL modo8_first: got %h bits %0d, required AB bits 0", out_b, bits_o);
        end
        offer(32'h000000CD, 2'b10, w);
        valid_in = 1'b0;
        checks++;
        if (out_b !== 8'hCD || valid_out !== 1'b1 || w !== 0) begin
            errors++;
            $display("[TB] FAIL modo8_b2b: got %h v%b waits %0d, required CD v1 waits 0", out_b, valid_out, w);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL modo8_end: got valid %b, required 0", valid_out);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        offer(32'h01020304, 2'b00, w);
        in_w = 32'h05060708;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge CLK);
                #1;
            end
            checks++;
            if (out_b !== 8'(i + 1) || valid_out !== 1'b1 || bits_o !== 2'(3 - (i % 4))) begin
                errors++;
                $display("[TB] FAIL stream_byte%0d: got %h v%b bits %0d, required %h v1 bits %0d",
                         i, out_b, valid_out, bits_o, i + 1, 3 - (i % 4));
            end
            checks++;
            if (ready_in !== ((i % 4) == 3)) begin
                errors++;
                $display("[TB] FAIL stream_ready%0d: got %b, required %b", i, ready_in, (i % 4) == 3);
            end
            if (i == 4) valid_in = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_stall();
        int w;
        offer(32'hA1B2C3D4, 2'b00, w);
        valid_in = 1'b0;
        @(posedge CLK);
        #1;
        ENB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (out_b !== 8'h00 || valid_out !== 1'b0 || bits_o !== 2'd2 || ready_in !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_%0d: got %h v%b bits %0d rdy %b, required 00 v0 bits 2 rdy 0",
                         i, out_b, valid_out, bits_o, ready_in);
            end
        end
        ENB = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (out_b !== 8'hC3 || bits_o !== 2'd1) begin
            errors++;
            $display("[TB] FAIL stall_resume_c3: got %h bits %0d, required C3 bits 1", out_b, bits_o);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (out_b !== 8'hD4 || bits_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stall_resume_d4: got %h bits %0d, required D4 bits 0", out_b, bits_o);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_cambio_modo();
        int w;
        logic [7:0] exp_b[3];
        exp_b = '{8'h22, 8'h33, 8'h44};
        offer(32'h11223344, 2'b00, w);
        valid_in = 1'b0;
        PCLK     = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (out_b !== exp_b[i] || valid_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL cambio_byte%0d: got %h v%b, required %h v1", i, out_b, valid_out, exp_b[i]);
            end
        end
        offer(32'hAABBCC55, 2'b10, w);
        valid_in = 1'b0;
        checks++;
        if (out_b !== 8'h55 || bits_o !== 2'd0) begin
            errors++;
            $display("[TB] FAIL cambio_next: got %h bits %0d, required 55 bits 0", out_b, bits_o);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cambio_end: got valid %b, required 0", valid_out);
        end
    endtask

    // Random words, modes, gaps and enable drops; the scoreboard does the
    // checking. valid_in/in/PCLK only change once the offered word is taken.
    task automatic test_random();
        logic acc;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            acc = valid_in && ready_in;
            @(posedge CLK);
            #1;
            ENB = ($urandom_range(0, 4) != 0);
            if (acc || !valid_in) begin
                valid_in = ($urandom_range(0, 2) != 0);
                in_w     = $urandom;
                PCLK     = 2'($urandom_range(0, 3));
            end
        end
        @(negedge CLK);
        acc = valid_in && ready_in;
        @(posedge CLK);
        #1;
        valid_in = 1'b0;
        ENB      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK);
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_drain: %0d bytes never emitted, required 0", sb.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_modo32();
        test_modos_16_8();
        test_back_to_back();
        test_stall();
        test_cambio_modo();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
